// File: rtl/button_event_detector.sv
// Multi-channel push-button conditioner: input synchroniser, stability-counter
// debounce, one-cycle press/release events and an optional auto-repeat train.
module button_event_detector #(
    parameter int NUM_BUTTONS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttonIn,
    output logic [NUM_BUTTONS-1:0] buttonLevel,
    output logic [NUM_BUTTONS-1:0] pressPulse,
    output logic [NUM_BUTTONS-1:0] releasePulse,
    output logic [NUM_BUTTONS-1:0] repeatPulse,
    output logic                   anyPress
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gChannel
        logic [SYNC_STAGES-1:0] syncChain;
        logic [CNT_W-1:0]       cnt;
        logic                   levelReg;
        logic                   pressReg;
        logic                   releaseReg;
        logic                   repeatBit;
        logic                   syncIn;
        logic                   accept;

        assign syncIn = syncChain[SYNC_STAGES-1];
        // A new level is accepted on the edge where it has already differed for DEBOUNCE_CYCLES-1 edges.
        assign accept = (syncIn != levelReg) && (cnt == CNT_LAST);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                syncChain  <= '0;
                cnt        <= '0;
                levelReg   <= 1'b0;
                pressReg   <= 1'b0;
                releaseReg <= 1'b0;
            end else begin
                syncChain  <= {syncChain[SYNC_STAGES-2:0], buttonIn[i]};
                pressReg   <= accept && syncIn;
                releaseReg <= accept && !syncIn;
                if (syncIn == levelReg) begin
                    cnt <= '0;
                end else if (accept) begin
                    cnt      <= '0;
                    levelReg <= syncIn;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        if (REPEAT_DELAY > 0) begin : gRepeat
            localparam int R_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
            localparam logic [R_W-1:0] FIRST_HIT = R_W'(REPEAT_DELAY - 1);
            localparam logic [R_W-1:0] WINDOW_LO = R_W'(REPEAT_DELAY);
            localparam logic [R_W-1:0] WINDOW_HI = R_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);

            logic [R_W-1:0] rcnt;
            logic           repeatReg;

            // After the first pulse rcnt only circulates inside [REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD-1].
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rcnt      <= '0;
                    repeatReg <= 1'b0;
                end else begin
                    repeatReg <= 1'b0;
                    if (accept || !levelReg) begin
                        rcnt <= '0;
                    end else if (rcnt == FIRST_HIT || rcnt == WINDOW_HI) begin
                        repeatReg <= 1'b1;
                        rcnt      <= WINDOW_LO;
                    end else begin
                        rcnt <= rcnt + R_W'(1);
                    end
                end
            end

            assign repeatBit = repeatReg;
        end else begin : gNoRepeat
            assign repeatBit = 1'b0;
        end

        assign buttonLevel[i]  = levelReg;
        assign pressPulse[i]   = pressReg;
        assign releasePulse[i] = releaseReg;
        assign repeatPulse[i]  = repeatBit;
    end

    assign anyPress = |pressPulse;

endmodule

// File: tb/tb_button_event_detector.sv
// Directed and randomized checks of button_event_detector against a windowed
// reference model of debounce acceptance and repeat timing.
module tb_button_event_detector;
    localparam int NB   = 4;
    localparam int SS   = 2;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXE = 4096;

    logic          clock;
    logic          reset;
    logic [NB-1:0] buttonIn;
    logic [NB-1:0] buttonLevel;
    logic [NB-1:0] pressPulse;
    logic [NB-1:0] releasePulse;
    logic [NB-1:0] repeatPulse;
    logic          anyPress;

    int checks   = 0;
    int failures = 0;

    button_event_detector #(
        .NUM_BUTTONS(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock), .reset(reset), .buttonIn(buttonIn),
        .buttonLevel(buttonLevel), .pressPulse(pressPulse),
        .releasePulse(releasePulse), .repeatPulse(repeatPulse),
        .anyPress(anyPress)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a level is accepted when the last DB synchronised samples all
    // differ from the current level; repeats fall at press+RD+m*RP while held.
    logic [NB-1:0] hist [0:MAXE-1];
    int            n;
    logic [NB-1:0] mLevel;
    logic [NB-1:0] expPress;
    logic [NB-1:0] expRelease;
    logic [NB-1:0] expRepeat;
    int            mPressEdge [NB];

    function automatic logic sampleAt(int idx, int ch);
        if (idx < 1) return 1'b0;
        return hist[idx][ch];
    endfunction

    task automatic modelClear();
        n          = 0;
        mLevel     = '0;
        expPress   = '0;
        expRelease = '0;
        expRepeat  = '0;
        for (int c = 0; c < NB; c++) mPressEdge[c] = 0;
    endtask

    task automatic modelEdge(input logic [NB-1:0] value);
        n++;
        if (n >= MAXE) begin
            $display("FAIL model_history observed=%0d expected<%0d", n, MAXE);
            $fatal(1, "history overflow");
        end
        hist[n] = value;
        for (int c = 0; c < NB; c++) begin
            logic acc;
            int   d;
            acc = 1'b1;
            for (int j = 0; j < DB; j++)
                if (sampleAt(n - SS - j, c) == mLevel[c]) acc = 1'b0;
            expPress[c]   = acc && !mLevel[c];
            expRelease[c] = acc && mLevel[c];
            expRepeat[c]  = 1'b0;
            if (mLevel[c] && !acc) begin
                d = n - mPressEdge[c];
                if (d >= RD && ((d - RD) % RP) == 0) expRepeat[c] = 1'b1;
            end
            if (acc) begin
                if (!mLevel[c]) mPressEdge[c] = n;
                mLevel[c] = !mLevel[c];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        chk("level", buttonLevel, mLevel);
        chk("press", pressPulse, expPress);
        chk("release", releasePulse, expRelease);
        chk("repeat", repeatPulse, expRepeat);
        chk("anyPress", {{(NB-1){1'b0}}, anyPress}, {{(NB-1){1'b0}}, |expPress});
    endtask

    task automatic step(input logic [NB-1:0] value);
        buttonIn = value;
        @(posedge clock);
        modelEdge(value);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        chk("rst_level", buttonLevel, '0);
        chk("rst_press", pressPulse, '0);
        chk("rst_release", releasePulse, '0);
        chk("rst_repeat", repeatPulse, '0);
        chk("rst_anyPress", {{(NB-1){1'b0}}, anyPress}, '0);
        modelClear();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Drives `hold` for holdLen edges then `after`; lat = edges after the first until the pulse.
    task automatic measure(input logic [NB-1:0] hold, input logic [NB-1:0] after, input int holdLen,
                           input int ch, input logic rel, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step((i <= holdLen) ? hold : after);
            if ((rel ? releasePulse[ch] : pressPulse[ch]) === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    initial begin
        int            lat;
        int            rc;
        int            repq[$];
        int            expOff[5];
        logic [NB-1:0] v;

        expOff   = '{10, 13, 16, 19, 22};
        reset    = 1'b0;
        buttonIn = '0;
        #2;
        doReset();
        for (int i = 0; i < 4; i++) step('0);

        // clean press and release on ch0
        measure(4'b0001, 4'b0001, 99, 0, 1'b0, lat);
        chkInt("ch0_press_latency", lat, 5);
        chk("ch0_only_level", buttonLevel, 4'b0001);
        measure(4'b0000, 4'b0000, 99, 0, 1'b1, lat);
        chkInt("ch0_release_latency", lat, 5);

        // ch1 glitch then a minimal accepted hold
        for (int i = 0; i < 3; i++) step(4'b0010);
        for (int i = 0; i < 8; i++) step(4'b0000);
        chk("ch1_glitch_level", buttonLevel, 4'b0000);
        measure(4'b0010, 4'b0000, 4, 1, 1'b0, lat);
        chkInt("ch1_press_after_glitch", lat, 5);
        for (int i = 0; i < 12; i++) step(4'b0000);

        // ch2 press, hold, release, no repeats afterwards
        measure(4'b0100, 4'b0100, 99, 2, 1'b0, lat);
        for (int i = 0; i < 6; i++) step(4'b0100);
        measure(4'b0000, 4'b0000, 99, 2, 1'b1, lat);
        chkInt("ch2_release_latency", lat, 5);
        rc = 0;
        for (int i = 0; i < 15; i++) begin
            step(4'b0000);
            if (repeatPulse[2]) rc++;
        end
        chkInt("ch2_repeat_after_release", rc, 0);

        // ch3 long hold: repeat offsets from the press pulse
        measure(4'b1000, 4'b1000, 99, 3, 1'b0, lat);
        chkInt("ch3_press_latency", lat, 5);
        for (int s = 1; s <= 24; s++) begin
            step(4'b1000);
            if (repeatPulse[3]) repq.push_back(s);
        end
        chkInt("ch3_repeat_count", repq.size(), 5);
        for (int i = 0; i < repq.size() && i < 5; i++) chkInt("ch3_repeat_offset", repq[i], expOff[i]);
        measure(4'b0000, 4'b0000, 99, 3, 1'b1, lat);
        chkInt("ch3_release_latency", lat, 5);
        rc = repeatPulse[3] ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            step(4'b0000);
            if (repeatPulse[3]) rc++;
        end
        chkInt("ch3_repeat_after_release", rc, 0);

        // simultaneous press on ch0 and ch2
        measure(4'b0101, 4'b0101, 99, 0, 1'b0, lat);
        chkInt("sim_press_latency", lat, 5);
        chk("sim_press_both", pressPulse, 4'b0101);
        chk("sim_anyPress_high", {{(NB-1){1'b0}}, anyPress}, 4'b0001);
        step(4'b0101);
        chk("sim_anyPress_low", {{(NB-1){1'b0}}, anyPress}, 4'b0000);
        for (int i = 0; i < 8; i++) step(4'b0000);

        // reset while ch1 is mid-repeat and ch0 mid-debounce
        measure(4'b0010, 4'b0010, 99, 1, 1'b0, lat);
        for (int i = 0; i < 12; i++) step(4'b0010);
        step(4'b0011);
        step(4'b0011);
        doReset();
        measure(4'b0010, 4'b0010, 99, 1, 1'b0, lat);
        chkInt("post_reset_press_latency", lat, 5);
        for (int i = 0; i < 10; i++) step(4'b0000);

        // randomized levels with occasional glitches and resets
        v = '0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NB; c++)
                if ($urandom_range(0, 5) == 0) v[c] = ~v[c];
            if ($urandom_range(0, 299) == 0) doReset();
            step(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
